shot_controller: RTL and testbench

SHOT_CONTROLLER -- requirements
Module: shot_controller

---
 rtl/shot_controller.sv | 159 +++++++++++++++
 tb/tb_shot_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shot_controller.sv
// rtl/shot_controller.sv - one-shot-at-a-time battleship fire controller with sink halo and scoring.
module shot_controller #(
    parameter int NUM_SHIPS = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fire_valid,
    output logic                   fire_ready,
    input  logic [3:0]             fire_row,
    input  logic [3:0]             fire_col,
    input  logic [299:0]           ship_map,
    input  logic [3*NUM_SHIPS-1:0] ship_len,
    output logic [99:0]            shot,
    output logic [99:0]            is_ship,
    output logic [99:0]            ship_sunk,
    output logic                   resp_valid,
    output logic [2:0]             resp_code,
    output logic [2:0]             resp_ship,
    output logic [6:0]             shot_count,
    output logic [2:0]             sunk_count,
    output logic                   game_over
);

    typedef enum logic [2:0] {IDLE, FIRE, SINK, RESP, OVER} state_t;

    localparam logic [2:0] C_MISS    = 3'd0;
    localparam logic [2:0] C_HIT     = 3'd1;
    localparam logic [2:0] C_SUNK    = 3'd2;
    localparam logic [2:0] C_REPEAT  = 3'd3;
    localparam logic [2:0] C_INVALID = 3'd4;
    localparam logic [2:0] NS        = 3'(NUM_SHIPS);

    state_t       state, state_n;
    logic [3:0]   row_q, col_q;
    logic [99:0]  shot_mask;
    logic [2:0]   hits [0:7];
    logic [2:0]   len_a [0:7];
    logic [2:0]   code_q, ship_q, sink_id;

    logic [6:0]   idx, req_idx;
    logic [8:0]   base;
    logic [2:0]   cur_id, cur_len, cur_hits, hits_inc;
    logic         id_ok, will_sink, req_bad, req_rep;
    logic [99:0]  member, halo;

    assign idx     = {3'd0, row_q} * 7'd10 + {3'd0, col_q};
    assign req_idx = {3'd0, fire_row} * 7'd10 + {3'd0, fire_col};
    assign base    = {2'd0, idx} * 9'd3;
    assign cur_id  = ship_map[base +: 3];
    assign req_bad = (fire_row > 4'd9) || (fire_col > 4'd9);
    assign req_rep = !req_bad && shot_mask[req_idx];

    always_comb begin
        for (int k = 0; k < 8; k++) len_a[k] = 3'd0;
        for (int k = 1; k <= NUM_SHIPS; k++) len_a[k] = ship_len[3*(k-1) +: 3];
    end

    // Hits saturate at the ship length, so a zero-length ship can never reach the sink condition.
    always_comb begin
        cur_len   = len_a[cur_id];
        cur_hits  = hits[cur_id];
        hits_inc  = cur_hits + 3'd1;
        id_ok     = (cur_id != 3'd0) && (cur_id <= NS);
        will_sink = id_ok && (cur_len != 3'd0) && (cur_hits != cur_len) && (hits_inc == cur_len);
    end

    always_comb begin
        for (int i = 0; i < 100; i++) begin
            is_ship[i] = (ship_map[3*i +: 3] != 3'd0) && (ship_map[3*i +: 3] <= NS);
            member[i]  = (sink_id != 3'd0) && (ship_map[3*i +: 3] == sink_id);
        end
    end

    // Halo is the 3x3 dilation of the sunk ship, clipped at the grid edges so nothing wraps.
    always_comb begin
        halo = '0;
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) begin
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((r + dr >= 0) && (r + dr <= 9) && (c + dc >= 0) && (c + dc <= 9)) begin
                            if (member[(r + dr) * 10 + (c + dc)]) halo[r * 10 + c] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Pulses decode straight from state so an asynchronous reset kills them in the same cycle.
    assign shot       = (state == FIRE) ? (100'(1) << idx) : '0;
    assign ship_sunk  = (state == SINK) ? halo : '0;
    assign fire_ready = (state == IDLE);
    assign game_over  = (state == OVER);

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (fire_valid) state_n = (req_bad || req_rep) ? RESP : FIRE;
            FIRE: state_n = will_sink ? SINK : RESP;
            SINK: state_n = RESP;
            RESP: state_n = (sunk_count == NS) ? OVER : IDLE;
            OVER: state_n = OVER;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            shot_mask  <= '0;
            for (int k = 0; k < 8; k++) hits[k] <= 3'd0;
            code_q     <= 3'd0;
            ship_q     <= 3'd0;
            sink_id    <= 3'd0;
            shot_count <= 7'd0;
            sunk_count <= 3'd0;
            resp_valid <= 1'b0;
            resp_code  <= 3'd0;
            resp_ship  <= 3'd0;
        end else begin
            state      <= state_n;
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire_valid) begin
                        row_q  <= fire_row;
                        col_q  <= fire_col;
                        ship_q <= 3'd0;
                        code_q <= req_bad ? C_INVALID : C_REPEAT;
                    end
                end
                FIRE: begin
                    shot_mask[idx] <= 1'b1;
                    shot_count     <= shot_count + 7'd1;
                    if (id_ok) begin
                        if (cur_hits != cur_len) hits[cur_id] <= hits_inc;
                        code_q <= will_sink ? C_SUNK : C_HIT;
                        ship_q <= cur_id;
                        if (will_sink) sink_id <= cur_id;
                    end else begin
                        code_q <= C_MISS;
                        ship_q <= 3'd0;
                    end
                end
                SINK: sunk_count <= sunk_count + 3'd1;
                RESP: begin
                    resp_valid <= 1'b1;
                    resp_code  <= code_q;
                    resp_ship  <= ship_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shot_controller.sv
// tb/tb_shot_controller.sv - table-driven scoreboard bench for shot_controller.
module tb_shot_controller;

    localparam int NS = 5;
    localparam logic [2:0] C_MISS = 3'd0, C_HIT = 3'd1, C_SUNK = 3'd2, C_REPEAT = 3'd3, C_INVALID = 3'd4;

    logic           clk = 1'b0;
    logic           reset;
    logic           fire_valid;
    logic           fire_ready;
    logic [3:0]     fire_row, fire_col;
    logic [299:0]   ship_map;
    logic [3*NS-1:0] ship_len;
    logic [99:0]    shot, is_ship, ship_sunk;
    logic           resp_valid;
    logic [2:0]     resp_code, resp_ship;
    logic [6:0]     shot_count;
    logic [2:0]     sunk_count;
    logic           game_over;

    always #5 clk = ~clk;

    shot_controller #(.NUM_SHIPS(NS)) dut (
        .clk(clk), .reset(reset), .fire_valid(fire_valid), .fire_ready(fire_ready),
        .fire_row(fire_row), .fire_col(fire_col), .ship_map(ship_map), .ship_len(ship_len),
        .shot(shot), .is_ship(is_ship), .ship_sunk(ship_sunk), .resp_valid(resp_valid),
        .resp_code(resp_code), .resp_ship(resp_ship), .shot_count(shot_count),
        .sunk_count(sunk_count), .game_over(game_over)
    );

    typedef struct {
        logic [3:0]  row;
        logic [3:0]  col;
        logic [2:0]  code;
        logic [2:0]  ship;
        int          lat;
        logic [99:0] sunk;
    } vec_t;

    typedef struct {
        logic [2:0] code;
        logic [2:0] ship;
    } resp_t;

    vec_t        tbl [15];
    resp_t       sb [$];
    resp_t       mon_e;
    logic [99:0] exp_is_ship;
    int          vectors = 0;
    int          miscompares = 0;
    int          model_shots = 0;
    int          model_sunk = 0;

    task automatic chk(input string name, input logic [99:0] act, input logic [99:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [99:0] box(input int r0, input int r1, input int c0, input int c1);
        logic [99:0] m = '0;
        for (int r = r0; r <= r1; r++)
            for (int c = c0; c <= c1; c++) m[r*10+c] = 1'b1;
        return m;
    endfunction

    task automatic place(input int id, input int len, input int r0, input int c0,
                         input int dr, input int dc, input int cells);
        for (int j = 0; j < cells; j++) begin
            ship_map[3*((r0+j*dr)*10 + c0+j*dc) +: 3] = 3'(id);
            if (id >= 1 && id <= NS) exp_is_ship[(r0+j*dr)*10 + c0+j*dc] = 1'b1;
        end
        if (id >= 1 && id <= NS) ship_len[3*(id-1) +: 3] = 3'(len);
    endtask

    // Scoreboard consumer: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: got code %0d ship %0d expected no response", resp_code, resp_ship);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_code", resp_code, mon_e.code);
                chk("resp_ship", resp_ship, mon_e.ship);
            end
        end
    end

    task automatic wait_ready();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fire_ready) return;
        end
        chk("ready_timeout", fire_ready, 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [99:0] shot_acc, sunk_acc, exp_shot;
        bit overlap, got;
        int lat;
        wait_ready();
        fire_row = v.row;
        fire_col = v.col;
        fire_valid = 1'b1;
        sb.push_back('{v.code, v.ship});
        if (v.code <= C_SUNK) model_shots++;
        if (v.code == C_SUNK) model_sunk++;
        exp_shot = (v.code <= C_SUNK) ? (100'(1) << (int'(v.row)*10 + int'(v.col))) : '0;
        @(posedge clk);
        shot_acc = '0; sunk_acc = '0; overlap = 0; got = 0; lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            fire_valid = 1'b0;
            shot_acc |= shot;
            sunk_acc |= ship_sunk;
            if ((shot & ship_sunk) != '0) overlap = 1;
            if (resp_valid) begin
                lat = n;
                got = 1;
                break;
            end
        end
        chk("resp_seen", got, 1'b1);
        chk("latency", lat, v.lat);
        chk("shot_pulse", shot_acc, exp_shot);
        chk("sunk_pulse", sunk_acc, v.sunk);
        chk("no_overlap", overlap, 1'b0);
        chk("shot_count", shot_count, model_shots);
        chk("sunk_count", sunk_count, model_sunk);
        chk("game_over", game_over, model_sunk == NS);
        chk("fire_ready", fire_ready, model_sunk != NS);
    endtask

    initial begin
        reset = 1'b1;
        fire_valid = 1'b0;
        fire_row = 4'd0;
        fire_col = 4'd0;
        ship_map = '0;
        ship_len = '0;
        exp_is_ship = '0;
        place(1, 2, 0, 0, 0, 1, 2);
        place(2, 1, 0, 9, 0, 0, 1);
        place(3, 2, 7, 0, 1, 0, 2);
        place(4, 1, 9, 9, 0, 0, 1);
        place(5, 3, 3, 3, 0, 1, 3);
        place(6, 0, 5, 0, 0, 0, 1);
        place(7, 0, 5, 1, 0, 0, 1);

        tbl[0]  = '{4'd0,  4'd0,  C_HIT,     3'd1, 3, '0};
        tbl[1]  = '{4'd0,  4'd1,  C_SUNK,    3'd1, 4, box(0, 1, 0, 2)};
        tbl[2]  = '{4'd5,  4'd5,  C_MISS,    3'd0, 3, '0};
        tbl[3]  = '{4'd5,  4'd5,  C_REPEAT,  3'd0, 2, '0};
        tbl[4]  = '{4'd10, 4'd3,  C_INVALID, 3'd0, 2, '0};
        tbl[5]  = '{4'd3,  4'd12, C_INVALID, 3'd0, 2, '0};
        tbl[6]  = '{4'd0,  4'd9,  C_SUNK,    3'd2, 4, box(0, 1, 8, 9)};
        tbl[7]  = '{4'd0,  4'd1,  C_REPEAT,  3'd0, 2, '0};
        tbl[8]  = '{4'd7,  4'd0,  C_HIT,     3'd3, 3, '0};
        tbl[9]  = '{4'd5,  4'd0,  C_MISS,    3'd0, 3, '0};
        tbl[10] = '{4'd8,  4'd0,  C_SUNK,    3'd3, 4, box(6, 9, 0, 1)};
        tbl[11] = '{4'd9,  4'd9,  C_SUNK,    3'd4, 4, box(8, 9, 8, 9)};
        tbl[12] = '{4'd3,  4'd3,  C_HIT,     3'd5, 3, '0};
        tbl[13] = '{4'd3,  4'd4,  C_HIT,     3'd5, 3, '0};
        tbl[14] = '{4'd3,  4'd5,  C_SUNK,    3'd5, 4, box(2, 4, 2, 6)};

        #12;
        chk("rst_fire_ready", fire_ready, 1'b1);
        chk("rst_shot", shot, '0);
        chk("rst_ship_sunk", ship_sunk, '0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_code", resp_code, 3'd0);
        chk("rst_resp_ship", resp_ship, 3'd0);
        chk("rst_shot_count", shot_count, 7'd0);
        chk("rst_sunk_count", sunk_count, 3'd0);
        chk("rst_game_over", game_over, 1'b0);
        chk("is_ship", is_ship, exp_is_ship);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(tbl[i]);

        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            fire_row = 4'd1;
            fire_col = 4'd1;
            fire_valid = 1'b1;
            chk("over_ready", fire_ready, 1'b0);
            chk("over_shot", shot, '0);
        end
        @(negedge clk);
        fire_valid = 1'b0;
        chk("over_game_over", game_over, 1'b1);
        chk("over_shot_count", shot_count, 7'd11);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_shots = 0;
        model_sunk = 0;
        chk("rerst_shot_count", shot_count, 7'd0);
        chk("rerst_game_over", game_over, 1'b0);

        wait_ready();
        fire_row = 4'd5;
        fire_col = 4'd5;
        fire_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fire_valid = 1'b0;
        chk("fire_cycle_pulse", shot, 100'(1) << 55);
        reset = 1'b1;
        #1;
        chk("shot_abort", shot, '0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_shot_count", shot_count, 7'd0);
        chk("abort_fire_ready", fire_ready, 1'b1);

        run_vec('{4'd0, 4'd0, C_HIT,  3'd1, 3, '0});
        run_vec('{4'd5, 4'd5, C_MISS, 3'd0, 3, '0});

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
